timer_alarm_sched: RTL and testbench

- Multi-channel alarm scheduler placed beside the 64-bit free-running timer core.
- Shares the single time value among N_CH software alarm channels, each holding one deadline.
- Sequential min-scan selects the earliest armed deadline. One comparator watches it and raises a per-channel pending flag when the deadline is reached.
- The merged pending vector drives one interrupt line.

---
 rtl/timer_sched_pkg.sv | 16 +
 rtl/timer_sched_scan.sv | 59 +++++
 rtl/timer_alarm_sched.sv | 139 +++++++++++++
 tb/tb_timer_alarm_sched.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_sched_pkg.sv
// Shared types and constants for the timer alarm scheduler.
package timer_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic OP_ARM    = 1'b0;
  localparam logic OP_CANCEL = 1'b1;

  localparam int DEF_TIME_W = 64;
  localparam int DEF_N_CH   = 4;

endpackage

// File: rtl/timer_sched_scan.sv
// Sequential min-finder: visits one channel per cycle after start, and
// reports the earliest armed deadline (ties to lowest index) on done.
module timer_sched_scan
  import timer_sched_pkg::*;
#(
  parameter int N_CH   = DEF_N_CH,
  parameter int TIME_W = DEF_TIME_W,
  parameter int CH_W   = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N_CH-1:0]   armed,
  input  logic [TIME_W-1:0] deadlines [N_CH],
  output logic              done,
  output logic              found,
  output logic [CH_W-1:0]   best_ch
);

  logic              active;
  logic [CH_W-1:0]   idx;
  logic [TIME_W-1:0] min_r;
  logic              found_r;
  logic [CH_W-1:0]   best_r;
  logic              take;
  logic [TIME_W-1:0] cur_dl;

  // Evaluate the channel under the index; results include the current visit
  always_comb begin
    cur_dl  = deadlines[idx];
    take    = active && armed[idx] && (!found_r || (cur_dl < min_r));
    found   = found_r || take;
    best_ch = take ? idx : best_r;
    done    = active && (idx == CH_W'(N_CH - 1));
  end

  // Scan index and running minimum
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active  <= 1'b0;
      idx     <= '0;
      min_r   <= '0;
      found_r <= 1'b0;
      best_r  <= '0;
    end else if (start) begin
      active  <= 1'b1;
      idx     <= '0;
      found_r <= 1'b0;
      best_r  <= '0;
    end else if (active) begin
      idx     <= idx + CH_W'(1);
      found_r <= found;
      best_r  <= best_ch;
      if (take) min_r <= cur_dl;
      if (done) active <= 1'b0;
    end
  end

endmodule

// File: rtl/timer_alarm_sched.sv
// Multi-channel alarm scheduler sharing one timer value.
// Optional macro TIMER_SCHED_PERIODIC_EN adds per-channel periodic reload.
module timer_alarm_sched
  import timer_sched_pkg::*;
#(
  parameter int N_CH   = DEF_N_CH,
  parameter int TIME_W = DEF_TIME_W,
  parameter int CH_W   = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TIME_W-1:0] timer_value,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_op,
  input  logic [CH_W-1:0]   req_ch,
  input  logic [TIME_W-1:0] req_deadline,
`ifdef TIMER_SCHED_PERIODIC_EN
  input  logic [TIME_W-1:0] req_period,
`endif
  input  logic [N_CH-1:0]   pend_clr,
  output logic [N_CH-1:0]   pending,
  output logic              interrupt,
  output logic              next_valid,
  output logic [CH_W-1:0]   next_ch,
  output logic              busy
);

  state_t            state, state_nxt;
  logic [N_CH-1:0]   armed;
  logic [TIME_W-1:0] deadline [N_CH];
`ifdef TIMER_SCHED_PERIODIC_EN
  logic [TIME_W-1:0] period [N_CH];
`endif
  logic              accept, hit, scan_start;
  logic              scan_done, scan_found;
  logic [CH_W-1:0]   scan_best;
  logic [N_CH-1:0]   set_vec, pend_nxt;

  assign req_ready = (state != SCAN);
  assign busy      = (state == SCAN);
  assign accept    = req_valid && req_ready;
  assign hit       = (state == WAIT) && armed[next_ch] && (timer_value >= deadline[next_ch]);

  timer_sched_scan #(
    .N_CH   (N_CH),
    .TIME_W (TIME_W),
    .CH_W   (CH_W)
  ) u_scan (
    .clk       (clk),
    .rst       (rst),
    .start     (scan_start),
    .armed     (armed),
    .deadlines (deadline),
    .done      (scan_done),
    .found     (scan_found),
    .best_ch   (scan_best)
  );

  // Next state, scan launch and pending set/clear vector
  always_comb begin
    state_nxt  = state;
    scan_start = 1'b0;
    set_vec    = '0;
    case (state)
      IDLE: if (accept) begin
        state_nxt  = SCAN;
        scan_start = 1'b1;
      end
      SCAN: if (scan_done) state_nxt = scan_found ? WAIT : IDLE;
      WAIT: if (accept || hit) begin
        state_nxt  = SCAN;
        scan_start = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    // A cancel of the channel that hits in the same cycle suppresses the fire
    if (hit && !(accept && (req_op == OP_CANCEL) && (req_ch == next_ch)))
      set_vec[next_ch] = 1'b1;
    pend_nxt = (pending & ~pend_clr) | set_vec;
  end

  // FSM state, watched channel and pending/interrupt registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      next_valid <= 1'b0;
      next_ch    <= '0;
      pending    <= '0;
      interrupt  <= 1'b0;
    end else begin
      state     <= state_nxt;
      pending   <= pend_nxt;
      interrupt <= |pend_nxt;
      if (scan_start) begin
        next_valid <= 1'b0;
      end else if ((state == SCAN) && scan_done) begin
        next_valid <= scan_found;
        if (scan_found) next_ch <= scan_best;
      end
    end
  end

  // Channel storage: hit consumes first, a same-cycle request then overrides
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed <= '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        deadline[i] <= '0;
`ifdef TIMER_SCHED_PERIODIC_EN
        period[i]   <= '0;
`endif
      end
    end else begin
      if (hit) begin
`ifdef TIMER_SCHED_PERIODIC_EN
        if (period[next_ch] != '0)
          deadline[next_ch] <= deadline[next_ch] + period[next_ch];
        else
          armed[next_ch] <= 1'b0;
`else
        armed[next_ch] <= 1'b0;
`endif
      end
      if (accept) begin
        if (req_op == OP_ARM) begin
          deadline[req_ch] <= req_deadline;
          armed[req_ch]    <= 1'b1;
`ifdef TIMER_SCHED_PERIODIC_EN
          period[req_ch]   <= req_period;
`endif
        end else begin
          armed[req_ch] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_timer_alarm_sched.sv
// Directed bench for timer_alarm_sched with N_CH=4; the bench drives the timer.
module tb_timer_alarm_sched;
  import timer_sched_pkg::*;

  localparam int N  = 4;
  localparam int TW = 64;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [TW-1:0] timer_value;
  logic          req_valid;
  logic          req_ready;
  logic          req_op;
  logic [CW-1:0] req_ch;
  logic [TW-1:0] req_deadline;
`ifdef TIMER_SCHED_PERIODIC_EN
  logic [TW-1:0] req_period;
`endif
  logic [N-1:0]  pend_clr;
  logic [N-1:0]  pending;
  logic          interrupt;
  logic          next_valid;
  logic [CW-1:0] next_ch;
  logic          busy;

  always #5 clk = ~clk;

  timer_alarm_sched #(
    .N_CH   (N),
    .TIME_W (TW),
    .CH_W   (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .timer_value  (timer_value),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_ch       (req_ch),
    .req_deadline (req_deadline),
`ifdef TIMER_SCHED_PERIODIC_EN
    .req_period   (req_period),
`endif
    .pend_clr     (pend_clr),
    .pending      (pending),
    .interrupt    (interrupt),
    .next_valid   (next_valid),
    .next_ch      (next_ch),
    .busy         (busy)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [CW-1:0] ch;
    logic [TW-1:0] dl;
    logic [TW-1:0] t0;
    int            cycles;
    logic [N-1:0]  pend;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One clock edge; inputs and checks happen 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    timer_value = timer_value + 1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    timer_value = '0;
    req_valid = 1'b0;
    pend_clr = '0;
  endtask

  task automatic send(input logic op, input logic [CW-1:0] ch, input logic [TW-1:0] dl);
    int n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    chk("req_ready_before_send", 64'(req_ready), 64'd1);
    req_valid    = 1'b1;
    req_op       = op;
    req_ch       = ch;
    req_deadline = dl;
    tick();
    req_valid    = 1'b0;
  endtask

  task automatic wait_timer(input logic [TW-1:0] t);
    int n = 0;
    while (timer_value != t && n < 2000) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int k;
    logic nv4;
    logic [CW-1:0] nc4;
    int ord [3];
    int no;
    logic [N-1:0] prev;

    vecs[0] = '{ch: 2'd2, dl: 64'd100, t0: 64'd0,  cycles: 100, pend: 4'b0100};
    vecs[1] = '{ch: 2'd1, dl: 64'd10,  t0: 64'd50, cycles: 5,   pend: 4'b0010};
    vecs[2] = '{ch: 2'd3, dl: 64'd7,   t0: 64'd0,  cycles: 7,   pend: 4'b1000};
    vecs[3] = '{ch: 2'd0, dl: 64'd5,   t0: 64'd0,  cycles: 5,   pend: 4'b0001};
    vecs[4] = '{ch: 2'd3, dl: 64'hFFFF_FFFF_FFFF_FFFA, t0: 64'hFFFF_FFFF_FFFF_FFF0,
                cycles: 10, pend: 4'b1000};
    vecs[5] = '{ch: 2'd1, dl: 64'd0,   t0: 64'd0,  cycles: 5,   pend: 4'b0010};

    rst = 1'b1;
    timer_value = '0;
    req_valid = 1'b0;
    req_op = OP_ARM;
    req_ch = '0;
    req_deadline = '0;
`ifdef TIMER_SCHED_PERIODIC_EN
    req_period = '0;
`endif
    pend_clr = '0;
    #1;
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd1);
    do_reset();
    chk("rst_interrupt", 64'(interrupt), 64'd0);
    chk("rst_next_valid", 64'(next_valid), 64'd0);
    chk("rst_next_ch", 64'(next_ch), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    // Reset in the middle of a scan
    send(OP_ARM, 2'd1, 64'd50);
    tick();
    chk("midscan_busy", 64'(busy), 64'd1);
    chk("midscan_ready", 64'(req_ready), 64'd0);
    rst = 1'b1;
    tick();
    chk("midscan_rst_busy", 64'(busy), 64'd0);
    chk("midscan_rst_ready", 64'(req_ready), 64'd1);
    chk("midscan_rst_nv", 64'(next_valid), 64'd0);
    rst = 1'b0;
    timer_value = '0;
    tick();
    tick();
    tick();
    tick();
    chk("midscan_rst_stays_idle", 64'({busy, next_valid, pending}), 64'd0);

    // Table: single one-shot alarm, latency from accept to pending
    for (int i = 0; i < 6; i++) begin
      do_reset();
      timer_value = vecs[i].t0;
      send(OP_ARM, vecs[i].ch, vecs[i].dl);
      chk($sformatf("v%0d_busy", i), 64'(busy), 64'd1);
      k = 0;
      nv4 = 1'b0;
      nc4 = '0;
      while (pending == '0 && k < 300) begin
        tick();
        k++;
        if (k == 4) begin
          nv4 = next_valid;
          nc4 = next_ch;
        end
      end
      chk($sformatf("v%0d_cycles", i), 64'(k), 64'(vecs[i].cycles));
      chk($sformatf("v%0d_pending", i), 64'(pending), 64'(vecs[i].pend));
      chk($sformatf("v%0d_interrupt", i), 64'(interrupt), 64'd1);
      chk($sformatf("v%0d_nv_after_scan", i), 64'(nv4), 64'd1);
      chk($sformatf("v%0d_next_ch", i), 64'(nc4), 64'(vecs[i].ch));
      chk($sformatf("v%0d_nv_after_hit", i), 64'(next_valid), 64'd0);
      pend_clr = vecs[i].pend;
      tick();
      pend_clr = '0;
      chk($sformatf("v%0d_clr_pending", i), 64'(pending), 64'd0);
      chk($sformatf("v%0d_clr_interrupt", i), 64'(interrupt), 64'd0);
      for (int j = 0; j < 4; j++) tick();
      chk($sformatf("v%0d_idle", i), 64'({busy, next_valid}), 64'd0);
    end

    // Fire order with a tie between channels 1 and 3
    do_reset();
    send(OP_ARM, 2'd0, 64'd500);
    send(OP_ARM, 2'd1, 64'd300);
    send(OP_ARM, 2'd3, 64'd300);
    ord = '{-1, -1, -1};
    no = 0;
    prev = pending;
    while (pending != 4'b1011 && timer_value < 700) begin
      tick();
      for (int b = 0; b < N; b++) begin
        if (pending[b] && !prev[b]) begin
          if (no < 3) ord[no] = b;
          no++;
        end
      end
      prev = pending;
    end
    chk("order_count", 64'(no), 64'd3);
    chk("order_first", 64'(ord[0]), 64'd1);
    chk("order_second", 64'(ord[1]), 64'd3);
    chk("order_third", 64'(ord[2]), 64'd0);
    chk("order_pending", 64'(pending), 64'b1011);

    // Cancel before the deadline
    do_reset();
    send(OP_ARM, 2'd2, 64'd200);
    wait_timer(64'd150);
    send(OP_CANCEL, 2'd2, 64'd0);
    wait_timer(64'd260);
    chk("cancel_pending", 64'(pending), 64'd0);
    chk("cancel_nv", 64'(next_valid), 64'd0);
    chk("cancel_idle", 64'({busy, req_ready}), 64'b01);

    // Hit coincident with re-arm of the same channel
    do_reset();
    send(OP_ARM, 2'd0, 64'd40);
    wait_timer(64'd40);
    send(OP_ARM, 2'd0, 64'd90);
    chk("rearm_hit_pending", 64'(pending), 64'b0001);
    pend_clr = 4'b0001;
    tick();
    pend_clr = '0;
    chk("rearm_clr", 64'(pending), 64'd0);
    k = 0;
    while (!pending[0] && k < 200) begin
      tick();
      k++;
    end
    chk("rearm_second_fire_time", 64'(timer_value - 1), 64'd90);

    // Hit coincident with cancel of the same channel: cancel wins
    do_reset();
    send(OP_ARM, 2'd1, 64'd30);
    wait_timer(64'd30);
    send(OP_CANCEL, 2'd1, 64'd0);
    chk("cancel_hit_pending", 64'(pending), 64'd0);
    for (int j = 0; j < 10; j++) tick();
    chk("cancel_hit_later", 64'({pending, next_valid}), 64'd0);

    // Set and clear on the same bit: set wins
    do_reset();
    send(OP_ARM, 2'd2, 64'd20);
    wait_timer(64'd20);
    pend_clr = 4'b0100;
    tick();
    pend_clr = '0;
    chk("set_wins", 64'(pending), 64'b0100);
    chk("set_wins_irq", 64'(interrupt), 64'd1);

    // Hit on one channel coincident with arm of another
    do_reset();
    send(OP_ARM, 2'd0, 64'd25);
    wait_timer(64'd25);
    send(OP_ARM, 2'd3, 64'd27);
    chk("diff_ch_first", 64'(pending), 64'b0001);
    wait_timer(64'd40);
    chk("diff_ch_both", 64'(pending), 64'b1001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
